// File: rtl/alu_issue_ctrl_if.sv
// ALU operation bus: opcode and operands towards the ALU, 65-bit result and
// completion flag back from it.
interface alu_issue_ctrl_if;
    logic [5:0]  op_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [64:0] out;
    logic        finished;

    modport master (output op_sel, output a, output b, input out, input finished);
    modport slave  (input op_sel, input a, input b, output out, output finished);
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation per start request, holds the operands until the ALU
// finishes or the wait times out, then captures the 65-bit result into Z.
module alu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         op_in,
    input  logic [31:0]        a_in,
    input  logic [31:0]        b_in,
    alu_issue_ctrl_if.master   alu,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        z_lo,
    output logic [31:0]        z_hi,
    output logic               z_carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic [5:0]        op_sel_nx;
    logic [31:0]       a_nx, b_nx;
    logic              done_nx, err_nx;
    logic [31:0]       z_lo_nx, z_hi_nx;
    logic              z_carry_nx;

    function automatic logic op_valid(input logic [5:0] op);
        case (op)
            6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09,
            6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: op_valid = 1'b1;
            default:                                  op_valid = 1'b0;
        endcase
    endfunction

    assign cnt_inc = cnt + CNT_W'(1);
    assign busy    = (state != IDLE);

    // Next-state and next register values; a completion that coincides with
    // the timeout edge is treated as a normal capture.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        op_sel_nx  = alu.op_sel;
        a_nx       = alu.a;
        b_nx       = alu.b;
        done_nx    = 1'b0;
        err_nx     = err;
        z_lo_nx    = z_lo;
        z_hi_nx    = z_hi;
        z_carry_nx = z_carry;

        case (state)
            IDLE: begin
                if (start) begin
                    if (op_valid(op_in)) begin
                        op_sel_nx = op_in;
                        a_nx      = a_in;
                        b_nx      = b_in;
                        cnt_nx    = '0;
                        err_nx    = 1'b0;
                        state_nx  = ISSUE;
                    end else begin
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (alu.finished) begin
                    z_lo_nx    = alu.out[31:0];
                    z_hi_nx    = alu.out[63:32];
                    z_carry_nx = alu.out[64];
                    done_nx    = 1'b1;
                    err_nx     = 1'b0;
                    op_sel_nx  = '0;
                    a_nx       = '0;
                    b_nx       = '0;
                    state_nx   = IDLE;
                end else if (cnt_inc == TIMEOUT_VAL) begin
                    cnt_nx    = cnt_inc;
                    done_nx   = 1'b1;
                    err_nx    = 1'b1;
                    op_sel_nx = '0;
                    a_nx      = '0;
                    b_nx      = '0;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            alu.op_sel <= '0;
            alu.a      <= '0;
            alu.b      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            z_lo       <= '0;
            z_hi       <= '0;
            z_carry    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            alu.op_sel <= op_sel_nx;
            alu.a      <= a_nx;
            alu.b      <= b_nx;
            done       <= done_nx;
            err        <= err_nx;
            z_lo       <= z_lo_nx;
            z_hi       <= z_hi_nx;
            z_carry    <= z_carry_nx;
        end
    end

endmodule
